// File: rtl/fp_add_unit.sv
// fp_add_unit - pipelined IEEE-754 single-precision add/subtract unit.
//
// Takes ops from the FP-add reservation station with a valid/ready handshake.
// Three stages (unpack/align, add, normalize/pack) feed an output register.
// That register holds the result on the CDB port until the arbiter grants it.
// Rounding is truncation. Denormal inputs are flushed to zero. NaN results
// are the canonical 0x7FC00000.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         issue handshake
//   in_op                     0 = A+B, 1 = A-B
//   in_a, in_b                operands
//   in_tag                    reservation-station tag
//   out_valid/out_grant       CDB handshake; the result is held until granted
//   out_result, out_tag       broadcast result and its tag
//   busy                      any stage or the output register occupied
module fp_add_unit #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_grant,
  output logic             busy
);
  localparam int          STAGES = 3;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  // Aligned operands. mag_* hold {hidden, fraction, guard, round, sticky}.
  typedef struct packed {
    logic             sign;
    logic [7:0]       exp;
    logic [26:0]      mag_l;
    logic [26:0]      mag_s;
    logic             eff_sub;
    logic             spec;
    logic [31:0]      spec_val;
    logic [TAG_W-1:0] tag;
  } align_t;

  typedef struct packed {
    logic             sign;
    logic [7:0]       exp;
    logic [27:0]      sum;
    logic             spec;
    logic [31:0]      spec_val;
    logic [TAG_W-1:0] tag;
  } sum_t;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic              stall, accept;
  logic [STAGES:1]   vld_pipe;
  align_t            s1_d, s1_q;
  sum_t              s2_d, s2_q;
  res_t              s3_d, s3_q;

  assign stall    = out_valid & ~out_grant;
  assign in_ready = ~stall & ~rst;
  assign accept   = in_valid & in_ready;
  assign busy     = (|vld_pipe) | out_valid;

  // ---------------- stage 1: unpack / classify / align ----------------
  logic        sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [30:0] mag_a, mag_b;
  logic [7:0]  el, es, diff;
  logic [23:0] ml, ms;
  logic [26:0] sm, lost_mask;

  always_comb begin
    s1_d      = '0;
    lost_mask = '0;
    sa     = in_a[31];
    sb     = in_b[31] ^ in_op;
    a_zero = (in_a[30:23] == 8'd0);
    b_zero = (in_b[30:23] == 8'd0);
    a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'd0);
    b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'd0);
    a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
    b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'd0);
    // Zeroing the whole magnitude flushes denormals and drops the hidden bit.
    mag_a  = a_zero ? 31'd0 : in_a[30:0];
    mag_b  = b_zero ? 31'd0 : in_b[30:0];
    swap   = mag_b > mag_a;
    el     = swap ? mag_b[30:23] : mag_a[30:23];
    es     = swap ? mag_a[30:23] : mag_b[30:23];
    ml     = swap ? {~b_zero, mag_b[22:0]} : {~a_zero, mag_a[22:0]};
    ms     = swap ? {~a_zero, mag_a[22:0]} : {~b_zero, mag_b[22:0]};
    diff   = el - es;
    sm     = {ms, 3'b000};

    s1_d.sign    = swap ? sb : sa;
    s1_d.exp     = el;
    s1_d.mag_l   = {ml, 3'b000};
    s1_d.eff_sub = sa ^ sb;
    s1_d.tag     = in_tag;
    if (diff >= 8'd27) begin
      s1_d.mag_s = '0;
    end else begin
      // The sticky bit keeps a borrow alive when nonzero bits were shifted out.
      lost_mask  = (27'd1 << diff) - 27'd1;
      s1_d.mag_s = (sm >> diff) | {26'd0, |(sm & lost_mask)};
    end

    s1_d.spec = 1'b1;
    if (a_nan || b_nan)        s1_d.spec_val = QNAN;
    else if (a_inf && b_inf)   s1_d.spec_val = (sa == sb) ? {sa, 8'hFF, 23'd0} : QNAN;
    else if (a_inf)            s1_d.spec_val = {sa, 8'hFF, 23'd0};
    else if (b_inf)            s1_d.spec_val = {sb, 8'hFF, 23'd0};
    else if (a_zero && b_zero && sa && sb) s1_d.spec_val = 32'h8000_0000;
    else                       s1_d.spec = 1'b0;
  end

  // ---------------- stage 2: mantissa add / subtract ----------------
  // mag_l >= mag_s after the swap, so the difference never goes negative.
  always_comb begin
    s2_d          = '0;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.tag      = s1_q.tag;
    s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.mag_l} - {1'b0, s1_q.mag_s})
                                 : ({1'b0, s1_q.mag_l} + {1'b0, s1_q.mag_s});
  end

  // ---------------- stage 3: normalize / pack ----------------
  logic [4:0]        lzc;
  logic [26:0]       norm;
  logic [22:0]       frac;
  logic signed [9:0] exp_n;
  logic              unused_norm;

  always_comb begin
    // Ascending scan: the highest set bit wins, giving a priority encoder.
    lzc = '0;
    for (int i = 0; i < 27; i++) if (s2_q.sum[i]) lzc = 5'(26 - i);
    norm = s2_q.sum[26:0] << lzc;
    if (s2_q.sum[27]) begin
      frac  = s2_q.sum[26:4];
      exp_n = $signed({2'b00, s2_q.exp}) + 10'sd1;
    end else begin
      frac  = norm[25:3];
      exp_n = $signed({2'b00, s2_q.exp}) - $signed({5'd0, lzc});
    end
    s3_d     = '0;
    s3_d.tag = s2_q.tag;
    if (s2_q.spec)                 s3_d.result = s2_q.spec_val;
    else if (s2_q.sum == 28'd0)    s3_d.result = 32'h0000_0000;
    else if (exp_n >= 10'sd255)    s3_d.result = {s2_q.sign, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)      s3_d.result = {s2_q.sign, 31'd0};
    else                           s3_d.result = {s2_q.sign, exp_n[7:0], frac};
  end

  // The hidden bit and the guard/round/sticky bits are discarded by truncation.
  assign unused_norm = ^{norm[26], norm[2:0]};

  // ---------------- pipeline control ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (!stall) begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      out_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        out_result <= s3_q.result;
        out_tag    <= s3_q.tag;
      end
    end
  end

  // Payload registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: tb/tb_fp_add_unit.sv
module tb_fp_add_unit;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_op;
  logic [31:0]      in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_grant;
  logic             busy;

  fp_add_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag),
    .out_grant(out_grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Truncating reference for normal-range operands, done with wide integers:
  // the larger significand is shifted left instead of the smaller right.
  function automatic logic [31:0] ref_add(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic   sa, sb, sl;
    int     ea, eb, el, es, d, p, e;
    longint ma, mb, ml, ms, r, m;
    sa = a[31]; sb = b[31] ^ op;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = longint'({1'b1, a[22:0]}); mb = longint'({1'b1, b[22:0]});
    if (b[30:0] > a[30:0]) begin sl = sb; el = eb; ml = mb; es = ea; ms = ma; end
    else                   begin sl = sa; el = ea; ml = ma; es = eb; ms = mb; end
    d = el - es;
    if (d >= 27) return {sl, el[7:0], ml[22:0]};
    r = (sa == sb) ? ((ml << d) + ms) : ((ml << d) - ms);
    if (r == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 64; i++) if (r[i]) p = i;
    e = el + p - 23 - d;
    m = (p >= 23) ? (r >> (p - 23)) : (r << (23 - p));
    if (e >= 255) return {sl, 8'hFF, 23'h0};
    if (e <= 0)   return {sl, 31'h0};
    return {sl, e[7:0], m[22:0]};
  endfunction

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] expv);
    int waits = 0;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    while (!in_ready && waits < 50) begin @(negedge clk); waits++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 (tag %0d)", tag);
    end else begin
      e.res = expv; e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_outstanding", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every result taken by the CDB is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_grant) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: got tag %0d result %h expected no result", out_tag, out_result);
        end else begin
          mon_e = sb_q.pop_front();
          chk("result", out_result, mon_e.res);
          chk("tag", 32'(out_tag), 32'(mon_e.tag));
        end
      end
    end
  end

  // Directed vectors: {op, a, b, expected}
  typedef struct { logic op; logic [31:0] a, b, r; } vec_t;
  vec_t vecs[16];

  logic [31:0] ra, rb;
  logic        rop;
  int          ea, eb;

  initial begin
    vecs[0]  = '{1'b1, 32'h40800000, 32'h3E800000, 32'h40700000}; // 4 - 0.25
    vecs[1]  = '{1'b0, 32'h40800000, 32'hC0800000, 32'h00000000}; // exact cancel
    vecs[2]  = '{1'b0, 32'h7F800000, 32'h40400000, 32'h7F800000}; // inf + 3
    vecs[3]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000}; // inf - inf
    vecs[4]  = '{1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000}; // NaN in
    vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000}; // -0 + -0
    vecs[6]  = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000}; // -0 - +0
    vecs[7]  = '{1'b0, 32'h3F800000, 32'h00000001, 32'h3F800000}; // denormal flushed
    vecs[8]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000}; // overflow
    vecs[9]  = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000}; // underflow
    vecs[10] = '{1'b0, 32'h3F800000, 32'h30800000, 32'h3F800000}; // shift 30
    vecs[11] = '{1'b1, 32'h3F800000, 32'h30800000, 32'h3F800000}; // shift 30, sub
    vecs[12] = '{1'b1, 32'h3F800000, 32'h33000000, 32'h3F7FFFFF}; // shift 25, borrow
    vecs[13] = '{1'b0, 32'hBF800000, 32'h3F000000, 32'hBF000000}; // -1 + 0.5
    vecs[14] = '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000}; // 1 - 2
    vecs[15] = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000}; // -inf + 1

    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_grant = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: 9.75 + 0.5625
    @(posedge clk); #1 out_grant = 1'b1;
    issue(1'b0, 32'h411C0000, 32'h3F100000, 4'd3, 32'h41250000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_before_3", 32'(out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("lat_at_3", 32'(out_valid), 32'd1);
    chk("lat_result", out_result, 32'h41250000);
    chk("lat_tag", 32'(out_tag), 32'd3);
    @(posedge clk); @(negedge clk);
    chk("lat_cleared", 32'(out_valid), 32'd0);

    // Directed vectors, back-to-back with grant held
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].r);
    drain();

    // Back-to-back stall
    @(posedge clk); #1 out_grant = 1'b0;
    issue(1'b0, 32'h3F800000, 32'h3F800000, 4'd0, 32'h40000000);
    issue(1'b0, 32'h40000000, 32'h3F800000, 4'd1, 32'h40400000);
    issue(1'b1, 32'h40400000, 32'h3F800000, 4'd2, 32'h40000000);
    issue(1'b0, 32'h3FC00000, 32'h3E800000, 4'd3, 32'h3FE00000);
    @(negedge clk);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold_tag", 32'({out_valid, out_tag}), 32'({1'b1, 4'd0}));
      chk("stall_hold_result", out_result, 32'h40000000);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 out_grant = 1'b1;
      @(posedge clk); #1 out_grant = 1'b0;
    end
    drain();
    @(negedge clk);
    chk("stall_empty_valid", 32'(out_valid), 32'd0);
    chk("stall_empty_busy", 32'(busy), 32'd0);

    // Reset mid-flight
    @(posedge clk); #1 out_grant = 1'b1;
    issue(1'b0, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000);
    issue(1'b0, 32'h40000000, 32'h40000000, 4'd6, 32'h40800000);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end

    // Random regression against the reference model
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      ea = int'($urandom_range(1, 254));
      case (i % 3)
        0:       eb = int'($urandom_range(1, 254));
        1:       eb = ea + int'($urandom_range(0, 6)) - 3;
        default: eb = ea - 27 - int'($urandom_range(0, 3));
      endcase
      if (eb < 1)   eb = 1;
      if (eb > 254) eb = 254;
      ra  = {1'($urandom), 8'(ea), 23'($urandom)};
      rb  = {1'($urandom), 8'(eb), 23'($urandom)};
      rop = 1'($urandom);
      issue(rop, ra, rb, 4'(i), ref_add(rop, ra, rb));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule

// File: doc/fp_add_unit.md
# fp_add_unit

Pipelined IEEE-754 single-precision add/subtract functional unit for the Tomasulo core. It accepts an operation from the FP-add reservation station through a valid/ready handshake and carries the reservation-station tag down three pipeline stages. It holds each result on the common data bus (CDB) port until the CDB arbiter grants it. It is the sequential, issue-and-broadcast counterpart to the combinational 32-bit FP adder.

## Interface
Parameters:
- TAG_W, 4: width of the reservation-station tag.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  reservation station presents an operation.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  1  0 = A+B, 1 = A−B.
- in_a  in  32  operand A, IEEE-754 single.
- in_b  in  32  operand B, IEEE-754 single.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result pending on CDB port.
- out_result  out  32  IEEE-754 single result.
- out_tag  out  TAG_W  tag of out_result.
- out_grant  in  1  CDB arbiter accepts the result this cycle.
- busy  out  1  any stage or the output register holds a valid op.

## Operation
- Stage 1 (unpack/align):
  - For subtract, invert B's sign.
  - Classify each operand as zero, inf, NaN or normal. Denormal inputs are flushed to signed zero.
  - Swap so |A| ≥ |B| (compare exponent, then mantissa).
  - Right-shift the smaller mantissa (hidden 1 restored) by the exponent difference. Shifts ≥ 27 yield 0.
  - Keep 3 extra low bits (guard, round, sticky), which are later discarded.
- Stage 2 (add): add the 27-bit mantissas on equal signs, otherwise subtract them. Result width is 28 bits. The sign is taken from the larger operand.
- Stage 3 (normalize/pack):
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift by leading-zero count (priority encoder) and decrement the exponent.
  - Rounding: truncate (round toward zero).
- Result rules:
  - Exact cancellation, or a zero mantissa sum → +0 (0x00000000).
  - −0 + −0 → 0x80000000.
  - Exponent ≥ 255 after normalization → signed inf.
  - Exponent ≤ 0 → signed zero.
  - inf ± finite → that inf.
  - inf + inf of the same sign → that inf.
  - inf + (−inf) → 0x7FC00000.
  - Any NaN input → 0x7FC00000.
  - Specials are decided in stage 1 and carried as a bypass value with a flag.
- Each stage has a valid bit; tag and op travel with the data.
- Output register:
  - Loaded from stage 3 when stage 3 is valid and the pipeline advances.
  - Cleared (out_valid = 0) when out_grant is high and no new result arrives.
  - out_grant is ignored while out_valid = 0.

## Timing
- Reset values: out_valid=0, out_result=0x00000000, out_tag=0, busy=0, all stage valid bits 0. in_ready=0 while rst is high and 1 on the first cycle after.
- stall = out_valid & ~out_grant. While stalled, every stage and the output register hold their contents. in_ready = ~stall & ~rst (combinational).
- An op is accepted on an edge where in_valid & in_ready. Its result appears with out_valid=1 after the 3rd following edge (latency 3).
- Throughput is one op per cycle when out_grant is held high, or when out_valid=0.
- Same-cycle out_grant and arriving stage-3 result: the output register loads the new result; out_valid stays 1.
- Bubbles propagate as valid=0; no reordering; results leave in issue order.
- rst mid-operation: all in-flight ops are discarded on that edge; no partial result is ever presented.
- busy = OR of the stage valid bits and out_valid.

## Test plan
- 9.75 + 0.5625 (A=0x411C0000, B=0x3F100000, op=0, tag=3), out_grant=1 → after 3 edges out_valid=1, out_result=0x41250000, out_tag=3; out_valid=0 on the next edge.
- 4.0 − 0.25 (A=0x40800000, B=0x3E800000, op=1) → 0x40700000. Separately, 4.0 + −4.0 (A=0x40800000, B=0xC0800000, op=0) → 0x00000000.
- inf + 3 (A=0x7F800000, B=0x40400000) → 0x7F800000. inf + −inf (A=0x7F800000, B=0xFF800000) → 0x7FC00000.
- Back-to-back stall: issue 4 ops on consecutive cycles (tags 0–3) with out_grant=0.
  - Tag 0 is held; in_ready falls on the cycle out_valid rises.
  - Pulse out_grant one cycle at a time → tags 0,1,2,3 emerge in order with no loss or duplication.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle after the 2nd accept → out_valid, busy, out_result, out_tag all 0. No result appears within 5 following cycles.
- Random regression: 1000 normal-range operand pairs compared against a truncating reference model → bit-exact match, including exponent-difference ≥ 27 cases.
